// File: rtl/dna_pattern_search.sv
// Streaming DNA pattern search: counts (overlapping) matches of a PAT_LEN-nucleotide pattern.
// Optional DNA_SEARCH_EARLY_EXIT_EN: stop at the first match instead of scanning the whole stream.
module dna_pattern_search #(
    parameter int PAT_LEN = 4,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset_N,
    input  logic                 ready,
    input  logic [2*PAT_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]     dna_length,
    input  logic                 nuc_valid,
    input  logic [1:0]           nuc,
    output logic                 nuc_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 found_it,
    output logic                 error,
    output logic [CNT_W-1:0]     match_count,
    output logic [LEN_W-1:0]     first_index
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

`ifdef DNA_SEARCH_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [LEN_W-1:0] PAT_LEN_L = LEN_W'(PAT_LEN);
    localparam logic [LEN_W-1:0] PAT_M1_L  = LEN_W'(PAT_LEN - 1);

    state_t               state_reg, state_next;
    logic [2*PAT_LEN-1:0] pattern_reg;
    logic [2*PAT_LEN-1:0] window_reg, window_next;
    logic [LEN_W-1:0]     len_reg, acc_cnt_reg, first_index_reg;
    logic [LEN_W-1:0]     acc_cnt_plus;
    logic [CNT_W-1:0]     match_count_reg;
    logic                 found_reg, error_reg;
    logic                 start, accept, last_accept, hit;

    // Window holds the most recent PAT_LEN nucleotides, newest in the LSBs.
    generate
        for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_window
            if (gi == 0) begin : g_newest
                assign window_next[1:0] = nuc;
            end else begin : g_shift
                assign window_next[2*gi+1:2*gi] = window_reg[2*gi-1:2*gi-2];
            end
        end
    endgenerate

    assign start        = (state_reg != SEARCH) && ready;
    assign accept       = (state_reg == SEARCH) && nuc_valid;
    assign acc_cnt_plus = acc_cnt_reg + LEN_W'(1);
    assign last_accept  = (acc_cnt_plus == len_reg);
    // Compare only once the window is fully populated by this search.
    assign hit          = (window_next == pattern_reg) && (acc_cnt_reg >= PAT_M1_L);

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (ready) begin
                    state_next = (dna_length < PAT_LEN_L) ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                if (accept && (last_accept || (EARLY_EXIT && hit))) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            pattern_reg     <= '0;
            window_reg      <= '0;
            len_reg         <= '0;
            acc_cnt_reg     <= '0;
            first_index_reg <= '0;
            match_count_reg <= '0;
            found_reg       <= 1'b0;
            error_reg       <= 1'b0;
        end else if (start) begin
            pattern_reg     <= pattern;
            len_reg         <= dna_length;
            window_reg      <= '0;
            acc_cnt_reg     <= '0;
            first_index_reg <= '0;
            match_count_reg <= '0;
            found_reg       <= 1'b0;
            error_reg       <= (dna_length < PAT_LEN_L);
        end else if (accept) begin
            window_reg  <= window_next;
            acc_cnt_reg <= acc_cnt_plus;
            if (hit) begin
                if (match_count_reg != '1) begin
                    match_count_reg <= match_count_reg + CNT_W'(1);
                end
                found_reg <= 1'b1;
                if (!found_reg) begin
                    first_index_reg <= acc_cnt_plus - PAT_LEN_L;
                end
            end
        end
    end

    assign nuc_ready   = (state_reg == SEARCH);
    assign busy        = (state_reg == SEARCH);
    assign done        = (state_reg == DONE);
    assign found_it    = found_reg;
    assign error       = error_reg;
    assign match_count = match_count_reg;
    assign first_index = first_index_reg;

endmodule

// File: tb/tb_dna_pattern_search.sv
// Randomised + directed bench for dna_pattern_search against a queue-based match-scanning model.
module tb_dna_pattern_search;

    localparam int PAT_LEN = 4;
    localparam int LEN_W   = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_S   = 2;

`ifdef DNA_SEARCH_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef logic [1:0] nq_t[$];

    logic                 clock = 1'b0;
    logic                 reset_N = 1'b0;
    logic                 ready = 1'b0;
    logic [2*PAT_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]     dna_length = '0;
    logic                 nuc_valid = 1'b0;
    logic [1:0]           nuc = 2'b00;

    logic                 nuc_ready, busy, done, found_it, error;
    logic [CNT_W-1:0]     match_count;
    logic [LEN_W-1:0]     first_index;
    logic                 nuc_ready_s, busy_s, done_s, found_it_s, error_s;
    logic [CNT_S-1:0]     match_count_s;
    logic [LEN_W-1:0]     first_index_s;

    int n_tests = 0;
    int n_fail  = 0;

    dna_pattern_search #(.PAT_LEN(PAT_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_N(reset_N), .ready(ready), .pattern(pattern),
        .dna_length(dna_length), .nuc_valid(nuc_valid), .nuc(nuc),
        .nuc_ready(nuc_ready), .busy(busy), .done(done), .found_it(found_it),
        .error(error), .match_count(match_count), .first_index(first_index)
    );

    // Narrow-counter copy sharing the same stimulus, to exercise saturation.
    dna_pattern_search #(.PAT_LEN(PAT_LEN), .LEN_W(LEN_W), .CNT_W(CNT_S)) dut_s (
        .clock(clock), .reset_N(reset_N), .ready(ready), .pattern(pattern),
        .dna_length(dna_length), .nuc_valid(nuc_valid), .nuc(nuc),
        .nuc_ready(nuc_ready_s), .busy(busy_s), .done(done_s), .found_it(found_it_s),
        .error(error_s), .match_count(match_count_s), .first_index(first_index_s)
    );

    always #5 clock = ~clock;

    // Model: phase 0=idle 1=search 2=done; seq holds every nucleotide accepted this search.
    int         phase = 0;
    bit [1:0]   m_pat[PAT_LEN];
    int         m_len = 0;
    bit         m_err = 1'b0;
    bit [1:0]   seq[$];
    bit         chk_en = 1'b0;

    function automatic int model_count(output int first);
        int c = 0;
        first = 0;
        for (int i = 0; i + PAT_LEN <= seq.size(); i++) begin
            bit ok = 1'b1;
            for (int k = 0; k < PAT_LEN; k++) begin
                if (seq[i+k] != m_pat[k]) ok = 1'b0;
            end
            if (ok) begin
                if (c == 0) first = i;
                c++;
            end
        end
        return c;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clock);
        if (!reset_N) begin
            phase = 0; m_len = 0; m_err = 1'b0; seq.delete();
            for (int k = 0; k < PAT_LEN; k++) m_pat[k] = 2'b00;
        end else if (phase != 1 && ready) begin
            for (int k = 0; k < PAT_LEN; k++) m_pat[k] = pattern[2*(PAT_LEN-1-k) +: 2];
            m_len = int'(dna_length);
            seq.delete();
            m_err = (m_len < PAT_LEN);
            phase = m_err ? 2 : 1;
        end else if (phase == 1 && nuc_valid) begin
            int f;
            seq.push_back(nuc);
            if (seq.size() == m_len) phase = 2;
            if (EARLY && model_count(f) > 0) phase = 2;
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            int c, f;
            c = model_count(f);
            check("nuc_ready",   int'(nuc_ready),   int'(phase == 1));
            check("busy",        int'(busy),        int'(phase == 1));
            check("done",        int'(done),        int'(phase == 2));
            check("error",       int'(error),       int'(m_err));
            check("found_it",    int'(found_it),    int'(c > 0));
            check("match_count", int'(match_count), sat(c, CNT_W));
            check("first_index", int'(first_index), f);
            check("match_count_sat", int'(match_count_s), sat(c, CNT_S));
            check("done_sat",    int'(done_s),      int'(phase == 2));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [1:0] code(input byte ch);
        case (ch)
            "A": return 2'b00;
            "C": return 2'b01;
            "G": return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic nq_t str2q(input string s);
        nq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(code(s[i]));
        return q;
    endfunction

    function automatic logic [2*PAT_LEN-1:0] str2pat(input string s);
        logic [2*PAT_LEN-1:0] r = '0;
        for (int k = 0; k < PAT_LEN; k++) r[2*(PAT_LEN-1-k) +: 2] = code(s[k]);
        return r;
    endfunction

    task automatic start(input logic [2*PAT_LEN-1:0] p, input int len);
        pattern = p;
        dna_length = LEN_W'(len);
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    // mode 0: valid always high; 1: toggling 1,0,...; 2: random gaps.
    task automatic feed(input nq_t q, input int mode, input int max_acc, input bit rnd_ready);
        int idx = 0;
        int budget = 2000;
        bit tog = 1'b1;
        bit acc;
        while (idx < q.size() && idx < max_acc && budget > 0) begin
            if (!nuc_ready) break;
            nuc = q[idx];
            case (mode)
                0: nuc_valid = 1'b1;
                1: begin nuc_valid = tog; tog = !tog; end
                default: nuc_valid = 1'($urandom_range(0, 1));
            endcase
            if (rnd_ready) ready = ($urandom_range(0, 7) == 0);
            acc = nuc_valid && nuc_ready;
            step();
            if (acc) idx++;
            budget--;
        end
        nuc_valid = 1'b0;
        ready = 1'b0;
        if (budget == 0) check("feed_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int b = 0;
        while (!done && b < 20) begin
            step();
            b++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic expect_result(input string name, input int cnt, input int first, input int err);
        int mf, mc;
        mc = model_count(mf);
        check({name, "_model_cnt"}, mc, cnt);
        check({name, "_model_first"}, mf, first);
        check({name, "_cnt"}, int'(match_count), cnt);
        check({name, "_first"}, int'(first_index), first);
        check({name, "_found"}, int'(found_it), int'(cnt > 0));
        check({name, "_err"}, int'(error), err);
        $display("[TB] %s: count=%0d first=%0d found=%0d err=%0d", name,
                 match_count, first_index, found_it, error);
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;
        check("rst_done", int'(done), 0);
        check("rst_cnt", int'(match_count), 0);
        reset_N = 1'b1;
        step();

        start(str2pat("ACGT"), 9);
        feed(str2q("AACGTACGT"), 0, 100, 1'b0);
        wait_done();
        expect_result("acgt", EARLY ? 1 : 2, 1, 0);
        check("acgt_accepted", seq.size(), EARLY ? 5 : 9);

        start(str2pat("AAAA"), 6);
        feed(str2q("AAAAAA"), 1, 100, 1'b0);
        wait_done();
        expect_result("aaaa_gaps", EARLY ? 1 : 3, 0, 0);

        start(str2pat("ACGT"), 3);
        wait_done();
        expect_result("short_len", 0, 0, 1);

        start(str2pat("AAAA"), 10);
        feed(str2q("AAAAAAAAAA"), 0, 100, 1'b0);
        wait_done();
        expect_result("sat", EARLY ? 1 : 7, 0, 0);
        check("sat_small_cnt", int'(match_count_s), EARLY ? 1 : 3);

        start(str2pat("ACGT"), 8);
        feed(str2q("CCCCCCCC"), 0, 100, 1'b0);
        wait_done();
        expect_result("nomatch", 0, 0, 0);
        start(str2pat("ACGT"), 9);
        feed(str2q("AACGTACGT"), 2, 100, 1'b0);
        wait_done();
        expect_result("restart", EARLY ? 1 : 2, 1, 0);

        start(str2pat("ACGT"), 9);
        feed(str2q("AACGTACGT"), 0, 3, 1'b0);
        reset_N = 1'b0;
        step();
        reset_N = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_cnt", int'(match_count), 0);
        step();
        check("midrst_idle", int'(busy | done), 0);

        for (int t = 0; t < 40; t++) begin
            logic [2*PAT_LEN-1:0] p;
            nq_t q;
            int len = $urandom_range(0, 40);
            int alpha = $urandom_range(1, 3);
            for (int k = 0; k < PAT_LEN; k++) p[2*k +: 2] = 2'($urandom_range(0, alpha));
            for (int i = 0; i < len; i++) q.push_back(2'($urandom_range(0, alpha)));
            start(p, len);
            if (len >= PAT_LEN) feed(q, 2, 1000, 1'b1);
            wait_done();
            $display("[TB] random %0d: len=%0d pat=%h count=%0d first=%0d", t, len, p,
                     match_count, first_index);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
